// File: rtl/mult_issue_ctrl.sv
// mult_issue_ctrl: issues one multiply, holds its operands stable, stalls until the result and writes it back once
module mult_issue_ctrl #(
    parameter int DATA_W   = 32,
    parameter int REG_W    = 5,
    parameter int TIMEOUT  = 40,
    parameter int GUARD    = 2,
    parameter int EXC_CODE = 4
) (
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic              i_issue_valid,
    input  logic [DATA_W-1:0] i_issue_opA,
    input  logic [DATA_W-1:0] i_issue_opB,
    input  logic [REG_W-1:0]  i_issue_rd,
    input  logic              i_flush,
    output logic [DATA_W-1:0] o_mult_operandA,
    output logic [DATA_W-1:0] o_mult_operandB,
    output logic              o_mult_ctrl,
    input  logic [DATA_W-1:0] i_mult_result,
    input  logic              i_mult_exception,
    input  logic              i_mult_resultRDY,
    output logic              o_stall,
    output logic              o_busy,
    output logic              o_wb_valid,
    output logic [REG_W-1:0]  o_wb_rd,
    output logic [DATA_W-1:0] o_wb_data,
    output logic              o_wb_exception,
    output logic              o_timeout_err
);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0]     GUARD_C = CW'(GUARD);
    localparam logic [CW-1:0]     LAST_C  = CW'(TIMEOUT - 1);
    localparam logic [REG_W-1:0]  RSTATUS = REG_W'(30);
    localparam logic [DATA_W-1:0] EXC_C   = DATA_W'(EXC_CODE);

    typedef enum logic [1:0] {IDLE, START, WAIT, DONE} state_t;

    state_t            r_state, w_next;
    logic [CW-1:0]     r_cnt;
    logic [DATA_W-1:0] r_opa, r_opb, r_wb_data;
    logic [REG_W-1:0]  r_rd, r_wb_rd;
    logic              r_wb_exc, r_timeout;
    logic              w_accept, w_rdy, w_timeout;

    assign w_accept  = (r_state == IDLE) && i_issue_valid && !i_flush;
    // RDY inside the guard window may be a leftover from the previous operation
    assign w_rdy     = (r_state == WAIT) && i_mult_resultRDY && (r_cnt >= GUARD_C) && !i_flush;
    assign w_timeout = (r_state == WAIT) && !w_rdy && (r_cnt == LAST_C) && !i_flush;

    assign o_mult_operandA = r_opa;
    assign o_mult_operandB = r_opb;
    assign o_wb_rd         = r_wb_rd;
    assign o_wb_data       = r_wb_data;
    assign o_wb_exception  = r_wb_exc;
    assign o_timeout_err   = r_timeout;
    assign o_busy          = r_state != IDLE;

    always_comb begin
        w_next      = r_state;
        o_stall     = 1'b0;
        o_mult_ctrl = 1'b0;
        o_wb_valid  = 1'b0;
        w_next      = i_flush ? IDLE :
                      (r_state == IDLE)  ? (i_issue_valid ? START : IDLE) :
                      (r_state == START) ? WAIT :
                      (r_state == WAIT)  ? ((w_rdy || w_timeout) ? DONE : WAIT) : IDLE;
        o_stall     = (r_state == IDLE) ? (i_issue_valid && !i_flush) : (r_state != DONE);
        o_mult_ctrl = (r_state == START) && !i_flush;
        o_wb_valid  = (r_state == DONE) && !i_flush;
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_opa     <= '0;
            r_opb     <= '0;
            r_rd      <= '0;
            r_wb_data <= '0;
            r_wb_rd   <= '0;
            r_wb_exc  <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_state <= w_next;
            r_cnt   <= (r_state == WAIT) ? r_cnt + 1'b1 : '0;
            if (w_accept) begin
                r_opa <= i_issue_opA;
                r_opb <= i_issue_opB;
                r_rd  <= i_issue_rd;
            end
            if (w_rdy) begin
                r_wb_data <= i_mult_exception ? EXC_C : i_mult_result;
                r_wb_rd   <= i_mult_exception ? RSTATUS : r_rd;
                r_wb_exc  <= i_mult_exception;
            end else if (w_timeout) begin
                r_wb_data <= EXC_C;
                r_wb_rd   <= RSTATUS;
                r_wb_exc  <= 1'b1;
                r_timeout <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_mult_issue_ctrl.sv
// tb_mult_issue_ctrl: randomized scenarios against a behavioural multiplier and latency/writeback model
module tb_mult_issue_ctrl;
    localparam int GUARD   = 2;
    localparam int TIMEOUT = 40;

    logic        clk, rst, iv, fl, mexc, mrdy;
    logic [31:0] opa, opb, mres;
    logic [4:0]  rdin;
    logic [31:0] oa, ob, wbd;
    logic [4:0]  wbrd;
    logic        mctrl, stall, busy, wbv, wbe, terr;

    int checks = 0;
    int failures = 0;

    int          ob_wb_t, ob_ctrl_t, ob_ctrl_n;
    logic [4:0]  ob_rd;
    logic [31:0] ob_data;
    logic        ob_exc;
    bit          ob_stall_ok, ob_ops_ok;

    mult_issue_ctrl dut (
        .i_clock(clk), .i_reset(rst), .i_issue_valid(iv), .i_issue_opA(opa), .i_issue_opB(opb),
        .i_issue_rd(rdin), .i_flush(fl), .o_mult_operandA(oa), .o_mult_operandB(ob),
        .o_mult_ctrl(mctrl), .i_mult_result(mres), .i_mult_exception(mexc), .i_mult_resultRDY(mrdy),
        .o_stall(stall), .o_busy(busy), .o_wb_valid(wbv), .o_wb_rd(wbrd), .o_wb_data(wbd),
        .o_wb_exception(wbe), .o_timeout_err(terr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // cycle (issue = 0) at which wb_valid is expected for a multiplier that raises RDY lat cycles after start
    function automatic int exp_wb_t(input int lat);
        int c;
        c = (lat - 1 < GUARD) ? GUARD : lat - 1;
        if (c > TIMEOUT - 1) c = TIMEOUT - 1;
        return 3 + c;
    endfunction

    function automatic bit exp_timeout(input int lat);
        return lat - 1 > TIMEOUT - 1;
    endfunction

    task automatic idle_cycle();
        @(negedge clk);
        iv = 0; fl = 0; mrdy = 0; mexc = 0; mres = $urandom;
        #1;
    endtask

    // issues one op and plays the multiplier; records observations only
    task automatic drive_op(input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd,
                            input int lat, input bit exc, input bit stale);
        int  start_t;
        bit  real_rdy;
        start_t = -1; ob_wb_t = -1; ob_ctrl_t = -1; ob_ctrl_n = 0; ob_stall_ok = 1; ob_ops_ok = 1;
        for (int t = 0; t < 60 && ob_wb_t < 0; t++) begin
            @(negedge clk);
            iv = 1; fl = 0; opa = a; opb = b; rdin = rd;
            real_rdy = (start_t >= 0) && (t >= start_t + lat);
            mrdy = real_rdy || (stale && t <= 3);
            mres = real_rdy ? a * b : $urandom;
            mexc = real_rdy ? exc : 1'($urandom_range(0, 1));
            #1;
            if (mctrl) begin
                ob_ctrl_n++;
                if (start_t < 0) begin start_t = t; ob_ctrl_t = t; end
            end
            if (wbv) begin ob_wb_t = t; ob_rd = wbrd; ob_data = wbd; ob_exc = wbe; end
            if (stall !== !wbv) ob_stall_ok = 0;
            if (t >= 1 && (oa !== a || ob !== b)) ob_ops_ok = 0;
        end
    endtask

    task automatic test_reset();
        rst = 1; iv = 0; fl = 0; mrdy = 0; mexc = 0; mres = 0; opa = 0; opb = 0; rdin = 0;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if ({oa, ob, wbd, wbrd, mctrl, stall, busy, wbv, wbe, terr} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got oa=%0h ob=%0h wbd=%0h wbrd=%0d flags=%b exp all 0",
                     oa, ob, wbd, wbrd, {mctrl, stall, busy, wbv, wbe, terr});
        end
        @(negedge clk); rst = 0;
    endtask

    task automatic test_basic();
        drive_op(32'd6, 32'd7, 5'd5, 4, 0, 0);
        checks++; if (ob_ctrl_t !== 1 || ob_ctrl_n !== 1) begin failures++; $display("FAIL basic_ctrl got t=%0d n=%0d exp t=1 n=1", ob_ctrl_t, ob_ctrl_n); end
        checks++; if (ob_wb_t !== 6) begin failures++; $display("FAIL basic_latency got %0d exp 6", ob_wb_t); end
        checks++; if ({ob_rd, ob_data, ob_exc} !== {5'd5, 32'd42, 1'b0}) begin failures++; $display("FAIL basic_wb got rd=%0d data=%0h exc=%b exp rd=5 data=2a exc=0", ob_rd, ob_data, ob_exc); end
        checks++; if (!ob_stall_ok) begin failures++; $display("FAIL basic_stall got bad stall exp high until DONE"); end
        idle_cycle();
        checks++; if ({wbv, busy, stall} !== 3'b000 || wbd !== 32'd42 || wbrd !== 5'd5) begin failures++; $display("FAIL basic_hold got wbv=%b busy=%b wbd=%0h wbrd=%0d exp 0 0 2a 5", wbv, busy, wbd, wbrd); end
    endtask

    task automatic test_negative();
        drive_op(32'hFFFF_FFFD, 32'd1000, 5'd9, 6, 0, 0);
        checks++; if ({ob_rd, ob_data, ob_exc} !== {5'd9, 32'hFFFF_F448, 1'b0}) begin failures++; $display("FAIL neg_wb got rd=%0d data=%0h exc=%b exp rd=9 data=fffff448 exc=0", ob_rd, ob_data, ob_exc); end
        checks++; if (!ob_ops_ok) begin failures++; $display("FAIL neg_operands got unstable exp stable"); end
        checks++; if (ob_wb_t !== exp_wb_t(6)) begin failures++; $display("FAIL neg_latency got %0d exp %0d", ob_wb_t, exp_wb_t(6)); end
        idle_cycle();
    endtask

    task automatic test_exception();
        drive_op(32'h7FFF_FFFF, 32'd2, 5'd12, 3, 1, 0);
        checks++; if ({ob_rd, ob_data, ob_exc} !== {5'd30, 32'd4, 1'b1}) begin failures++; $display("FAIL exc_wb got rd=%0d data=%0h exc=%b exp rd=30 data=4 exc=1", ob_rd, ob_data, ob_exc); end
        checks++; if (terr !== 1'b0) begin failures++; $display("FAIL exc_no_timeout got %b exp 0", terr); end
        idle_cycle();
    endtask

    task automatic test_stale_rdy();
        logic [31:0] a, b;
        for (int i = 0; i < 2; i++) begin
            int lat;
            lat = (i == 0) ? 1 : 5;
            a = $urandom; b = $urandom;
            drive_op(a, b, 5'd7, lat, 0, 1);
            checks++; if (ob_wb_t !== exp_wb_t(lat)) begin failures++; $display("FAIL stale_latency lat=%0d got %0d exp %0d", lat, ob_wb_t, exp_wb_t(lat)); end
            checks++; if (ob_data !== a * b || ob_rd !== 5'd7) begin failures++; $display("FAIL stale_data got %0h rd=%0d exp %0h rd=7", ob_data, ob_rd, a * b); end
            idle_cycle();
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 12; i++) begin
            logic [31:0] a, b, ed;
            logic [4:0]  rd, er;
            int lat;
            bit exc, stale, bad;
            a = $urandom; b = $urandom; rd = 5'($urandom_range(0, 31));
            if (i == 3) rd = 0;
            lat = $urandom_range(1, 15); exc = ($urandom_range(0, 3) == 0); stale = 1'($urandom_range(0, 1));
            drive_op(a, b, rd, lat, exc, stale);
            bad = exc || exp_timeout(lat);
            ed = bad ? 32'd4 : a * b;
            er = bad ? 5'd30 : rd;
            checks++; if (ob_wb_t !== exp_wb_t(lat) || ob_ctrl_t !== 1 || ob_ctrl_n !== 1) begin failures++; $display("FAIL rand_timing i=%0d got wb_t=%0d ctrl_t=%0d n=%0d exp %0d 1 1", i, ob_wb_t, ob_ctrl_t, ob_ctrl_n, exp_wb_t(lat)); end
            checks++; if ({ob_rd, ob_data, ob_exc} !== {er, ed, bad}) begin failures++; $display("FAIL rand_wb i=%0d got rd=%0d data=%0h exc=%b exp rd=%0d data=%0h exc=%b", i, ob_rd, ob_data, ob_exc, er, ed, bad); end
            checks++; if (!ob_ops_ok || !ob_stall_ok) begin failures++; $display("FAIL rand_stable i=%0d got ops=%b stall=%b exp 1 1", i, ob_ops_ok, ob_stall_ok); end
            if ($urandom_range(0, 1) == 1) idle_cycle();
        end
        idle_cycle();
    endtask

    task automatic test_back_to_back();
        drive_op(32'd11, 32'd13, 5'd3, 2, 0, 0);
        drive_op(32'd5, 32'd9, 5'd4, 3, 0, 1);
        checks++; if (ob_ctrl_t !== 1 || ob_ctrl_n !== 1) begin failures++; $display("FAIL b2b_ctrl got t=%0d n=%0d exp t=1 n=1", ob_ctrl_t, ob_ctrl_n); end
        checks++; if ({ob_rd, ob_data, ob_wb_t} !== {5'd4, 32'd45, exp_wb_t(3)}) begin failures++; $display("FAIL b2b_wb got rd=%0d data=%0d t=%0d exp rd=4 data=45 t=%0d", ob_rd, ob_data, ob_wb_t, exp_wb_t(3)); end
        idle_cycle();
    endtask

    task automatic test_timeout();
        drive_op(32'd3, 32'd3, 5'd8, 1000, 0, 0);
        checks++; if (ob_wb_t !== 3 + TIMEOUT - 1) begin failures++; $display("FAIL to_latency got %0d exp %0d", ob_wb_t, 3 + TIMEOUT - 1); end
        checks++; if ({ob_rd, ob_data, ob_exc} !== {5'd30, 32'd4, 1'b1}) begin failures++; $display("FAIL to_wb got rd=%0d data=%0h exc=%b exp rd=30 data=4 exc=1", ob_rd, ob_data, ob_exc); end
        idle_cycle();
        checks++; if (terr !== 1'b1) begin failures++; $display("FAIL to_flag got %b exp 1", terr); end
        drive_op(32'd2, 32'd8, 5'd1, 4, 0, 0);
        idle_cycle();
        checks++; if (terr !== 1'b1 || ob_data !== 32'd16) begin failures++; $display("FAIL to_sticky got terr=%b data=%0d exp 1 16", terr, ob_data); end
    endtask

    task automatic test_flush();
        for (int r = 0; r < 2; r++) begin
            int  f;
            bit  seen;
            f = (r == 0) ? 1 : $urandom_range(3, 10);
            @(negedge clk); iv = 1; fl = 0; opa = 9; opb = 9; rdin = 6; mrdy = 0; #1;
            for (int t = 1; t < f; t++) begin @(negedge clk); mrdy = 0; #1; end
            @(negedge clk); fl = 1; mrdy = 1; mres = 81; mexc = 0; #1;
            checks++; if ({mctrl, wbv} !== 2'b00) begin failures++; $display("FAIL flush_cycle f=%0d got ctrl=%b wbv=%b exp 0 0", f, mctrl, wbv); end
            @(negedge clk); fl = 0; iv = 0; #1;
            checks++; if ({busy, stall, wbv} !== 3'b000) begin failures++; $display("FAIL flush_idle f=%0d got busy=%b stall=%b wbv=%b exp 0 0 0", f, busy, stall, wbv); end
            seen = 0;
            for (int t = 0; t < 3; t++) begin @(negedge clk); #1; if (wbv) seen = 1; end
            checks++; if (seen) begin failures++; $display("FAIL flush_no_wb got wb_valid exp none"); end
            drive_op(32'd2, 32'd2, 5'd3, 4, 0, 1);
            checks++; if (ob_data !== 32'd4 || ob_wb_t !== exp_wb_t(4)) begin failures++; $display("FAIL flush_next got data=%0d t=%0d exp 4 %0d", ob_data, ob_wb_t, exp_wb_t(4)); end
            idle_cycle();
        end
    endtask

    task automatic test_reset_mid();
        bit seen;
        @(negedge clk); iv = 1; opa = 32'hDEAD; opb = 32'hBEEF; rdin = 2; mrdy = 0; #1;
        repeat (5) begin @(negedge clk); #1; end
        @(negedge clk); rst = 1; iv = 0; mrdy = 1; mres = 5; #1;
        @(negedge clk); #1;
        checks++;
        if ({oa, ob, wbd, wbrd, mctrl, stall, busy, wbv, wbe, terr} !== '0) begin
            failures++;
            $display("FAIL reset_mid got oa=%0h ob=%0h wbd=%0h wbrd=%0d flags=%b exp all 0",
                     oa, ob, wbd, wbrd, {mctrl, stall, busy, wbv, wbe, terr});
        end
        @(negedge clk); rst = 0;
        seen = 0;
        for (int t = 0; t < 4; t++) begin @(negedge clk); #1; if (wbv || busy) seen = 1; end
        checks++; if (seen) begin failures++; $display("FAIL reset_mid_no_wb got activity exp none"); end
        mrdy = 0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_negative();
        test_exception();
        test_stale_rdy();
        test_random();
        test_back_to_back();
        test_timeout();
        test_flush();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
